clk_div_gen: RTL and testbench
==============================

// Module: clk_div_gen
// PURPOSE
//   Synthesizable multi-channel successor to the behavioural PLL model. Runs in the
//   single reference clock domain and never creates derived clocks. For each channel
//   it produces a programmable-ratio clock-enable pulse and a divided toggle output.
//   It also runs a per-channel lock FSM with settle and lock timers and a bypass mode.
//   Sits between the top-level clock/reset and sub-modules that need slower enables.
// PARAMETERS
//   CH            2    number of independent channels
//   DIV_W         8    width of per-channel divide ratio
//   SETTLE_CYCLES 10   cycles after reset release before dividers start
//   LOCK_CYCLES   100  stable cycles in RUN before io_lock asserts
// PORTS
//   clock        in   1         single clock; all logic on posedge
//   reset        in   1         synchronous, active-high
//   io_bypass    in   CH        per-channel bypass: enable forced high every cycle
//   io_div       in   CH*DIV_W  per-channel ratio N, ch k at [k*DIV_W +: DIV_W]
//   io_clk_en    out  CH        one-cycle enable pulse every N cycles
//   io_clk_tgl   out  CH        toggles on every divider pulse (divide by 2N, 50% duty)
//   io_lock      out  CH        channel locked
//   io_pulse_cnt out  CH*16     only with CLK_DIV_GEN_PULSE_CNT_EN (see CONFIGURATION)
// BEHAVIOUR
//   - Reset: all outputs 0; FSM=SETTLE; div_q<=io_div; counters 0.
//     Reset mid-operation aborts everything at the next edge.
//   - Cycle numbering: cycle 1 = first posedge sampling reset=0.
//   - Effective ratio: Neff = (div_q==0) ? 1 : div_q. Width-limited to DIV_W; no overflow.
//   - Per-channel FSM:
//       SETTLE: count SETTLE_CYCLES cycles, then go to RUN.
//               Ratio changes here update div_q only.
//       RUN:    divider counter 0..Neff-1 wraps. Registered io_clk_en is high for one
//               cycle when the counter wraps. The first pulse is in cycle
//               SETTLE_CYCLES+Neff. Lock timer counts; go to LOCKED when it
//               reaches LOCK_CYCLES.
//       LOCKED: divider continues; io_lock=1.
//               io_lock rises in cycle SETTLE_CYCLES+LOCK_CYCLES after reset.
//   - Ratio change: io_div[k] != div_q[k] in RUN or LOCKED, at edge E:
//       div_q updates; divider counter and lock timer restart at 0; FSM goes to RUN.
//       io_lock=0 from E+1. Next pulse is Neff_new cycles after E.
//       io_lock re-asserts LOCK_CYCLES cycles after E if there are no further changes.
//   - Neff=1: io_clk_en is continuously high in RUN/LOCKED; io_clk_tgl toggles every cycle.
//   - Bypass: io_clk_en[k]=1 every cycle (combinational OR after the register).
//       Divider, io_clk_tgl, FSM and io_lock keep running unaffected.
//       Bypass toggling does not count as a ratio change.
//   - Channels are fully independent; simultaneous changes on several channels are
//     handled per channel in the same cycle.
// CONFIGURATION
//   CLK_DIV_GEN_PULSE_CNT_EN defined:
//     - adds io_pulse_cnt: per-channel 16-bit counter of divider pulses;
//     - bypass-forced pulses are not counted;
//     - wraps 0xFFFF->0; reset to 0; not cleared by ratio change.
//   Not defined: port and counters absent; all other behaviour is identical.
// TESTING
//   1. CH=2, div={4,2}, no bypass, reset for 3 cycles then release:
//        ch1 pulses at cycles 12,14,..; ch0 at cycles 14,18,..;
//        both io_lock rise at cycle 110.
//   2. Locked ch0 N=4, change io_div to 3 at edge E:
//        io_lock=0 at E+1; pulses at E+3,E+6; io_lock=1 at E+100.
//   3. io_div=0 and io_div=1: io_clk_en high every cycle after cycle 10;
//        io_clk_tgl toggles every cycle.
//   4. Assert io_bypass[1] for 20 cycles during LOCKED:
//        io_clk_en[1]=1 throughout; io_lock[1] stays 1;
//        pulse phase after release matches an uninterrupted run.
//   5. Assert reset for 1 cycle while LOCKED: all outputs 0 next cycle;
//        startup timing from test 1 repeats exactly.
//   6. With CLK_DIV_GEN_PULSE_CNT_EN, N=1 for 65537 pulses:
//        io_pulse_cnt wraps to 1; bypass pulses do not increment it.

Source files
------------

// File: rtl/clk_div_gen_if.sv
// Channel bundle for clk_div_gen: ratio/bypass controls in, enables/toggles/lock status out.
// The io_pulse_cnt member exists only when CLK_DIV_GEN_PULSE_CNT_EN is defined.
interface clk_div_gen_if #(
   parameter int CH    = 2,
   parameter int DIV_W = 8
);
   logic [CH-1:0]       io_bypass;
   logic [CH*DIV_W-1:0] io_div;
   logic [CH-1:0]       io_clk_en;
   logic [CH-1:0]       io_clk_tgl;
   logic [CH-1:0]       io_lock;
`ifdef CLK_DIV_GEN_PULSE_CNT_EN
   logic [CH*16-1:0]    io_pulse_cnt;

   modport master (
      output io_bypass, io_div,
      input  io_clk_en, io_clk_tgl, io_lock, io_pulse_cnt
   );
   modport slave (
      input  io_bypass, io_div,
      output io_clk_en, io_clk_tgl, io_lock, io_pulse_cnt
   );
`else
   modport master (
      output io_bypass, io_div,
      input  io_clk_en, io_clk_tgl, io_lock
   );
   modport slave (
      input  io_bypass, io_div,
      output io_clk_en, io_clk_tgl, io_lock
   );
`endif
endinterface

// File: rtl/clk_div_gen.sv
// Multi-channel clock-enable divider with per-channel settle/lock FSM and bypass, single clock domain.
// Optional per-channel pulse counters are built when CLK_DIV_GEN_PULSE_CNT_EN is defined.
module clk_div_gen #(
   parameter int CH            = 2,
   parameter int DIV_W         = 8,
   parameter int SETTLE_CYCLES = 10,
   parameter int LOCK_CYCLES   = 100
) (
   input  logic          clock,
   input  logic          reset,
   clk_div_gen_if.slave  bus
);
   localparam int TMR_MAX = (SETTLE_CYCLES > LOCK_CYCLES) ? SETTLE_CYCLES : LOCK_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
   localparam logic [TMR_W-1:0] LOCK_LAST   = TMR_W'(LOCK_CYCLES - 1);

   typedef enum logic [1:0] {ST_SETTLE, ST_RUN, ST_LOCKED} state_t;

   state_t           r_state     [CH];
   state_t           w_state_nx  [CH];
   logic [DIV_W-1:0] r_div_q     [CH];
   logic [DIV_W-1:0] w_div_q_nx  [CH];
   logic [DIV_W-1:0] r_div_cnt   [CH];
   logic [DIV_W-1:0] w_div_cnt_nx[CH];
   logic [TMR_W-1:0] r_tmr       [CH];
   logic [TMR_W-1:0] w_tmr_nx    [CH];
   logic [DIV_W-1:0] w_div_in    [CH];
   logic [DIV_W-1:0] w_neff      [CH];
   logic [CH-1:0]    w_wrap;
   logic [CH-1:0]    r_en, w_en_nx;
   logic [CH-1:0]    r_tgl, w_tgl_nx;
   logic [CH-1:0]    r_lock, w_lock_nx;
`ifdef CLK_DIV_GEN_PULSE_CNT_EN
   logic [15:0]      r_pcnt      [CH];
   logic [15:0]      w_pcnt_nx   [CH];
`endif

   // A programmed ratio of 0 behaves like 1 so the divider always makes progress.
   for (genvar g = 0; g < CH; g++) begin : g_ch
      assign w_div_in[g] = bus.io_div[g*DIV_W +: DIV_W];
      assign w_neff[g]   = (r_div_q[g] == '0) ? DIV_W'(1) : r_div_q[g];
      assign w_wrap[g]   = (r_div_cnt[g] == (w_neff[g] - DIV_W'(1)));
`ifdef CLK_DIV_GEN_PULSE_CNT_EN
      assign bus.io_pulse_cnt[g*16 +: 16] = r_pcnt[g];
`endif
   end

   always_comb begin
      w_en_nx   = '0;
      w_tgl_nx  = r_tgl;
      w_lock_nx = r_lock;
      for (int k = 0; k < CH; k++) begin
         w_state_nx[k]   = r_state[k];
         w_div_q_nx[k]   = r_div_q[k];
         w_div_cnt_nx[k] = r_div_cnt[k];
         w_tmr_nx[k]     = r_tmr[k];
`ifdef CLK_DIV_GEN_PULSE_CNT_EN
         w_pcnt_nx[k]    = r_pcnt[k];
`endif
         case (r_state[k])
            ST_SETTLE: begin
               w_div_q_nx[k] = w_div_in[k];
               if (r_tmr[k] == SETTLE_LAST) begin
                  w_state_nx[k]   = ST_RUN;
                  w_tmr_nx[k]     = '0;
                  w_div_cnt_nx[k] = '0;
               end else begin
                  w_tmr_nx[k] = r_tmr[k] + TMR_W'(1);
               end
            end
            ST_RUN, ST_LOCKED: begin
               // A new ratio restarts phase and lock qualification from scratch.
               if (w_div_in[k] != r_div_q[k]) begin
                  w_div_q_nx[k]   = w_div_in[k];
                  w_div_cnt_nx[k] = '0;
                  w_tmr_nx[k]     = '0;
                  w_state_nx[k]   = ST_RUN;
                  w_lock_nx[k]    = 1'b0;
               end else begin
                  if (w_wrap[k]) begin
                     w_div_cnt_nx[k] = '0;
                     w_en_nx[k]      = 1'b1;
                     w_tgl_nx[k]     = ~r_tgl[k];
`ifdef CLK_DIV_GEN_PULSE_CNT_EN
                     w_pcnt_nx[k]    = r_pcnt[k] + 16'd1;
`endif
                  end else begin
                     w_div_cnt_nx[k] = r_div_cnt[k] + DIV_W'(1);
                  end
                  if (r_state[k] == ST_RUN) begin
                     if (r_tmr[k] == LOCK_LAST) begin
                        w_state_nx[k] = ST_LOCKED;
                        w_lock_nx[k]  = 1'b1;
                     end else begin
                        w_tmr_nx[k] = r_tmr[k] + TMR_W'(1);
                     end
                  end
               end
            end
            default: begin
               w_state_nx[k]   = ST_SETTLE;
               w_tmr_nx[k]     = '0;
               w_div_cnt_nx[k] = '0;
               w_lock_nx[k]    = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < CH; k++) begin
            r_state[k]   <= ST_SETTLE;
            r_div_q[k]   <= w_div_in[k];
            r_div_cnt[k] <= '0;
            r_tmr[k]     <= '0;
`ifdef CLK_DIV_GEN_PULSE_CNT_EN
            r_pcnt[k]    <= '0;
`endif
         end
         r_en   <= '0;
         r_tgl  <= '0;
         r_lock <= '0;
      end else begin
         for (int k = 0; k < CH; k++) begin
            r_state[k]   <= w_state_nx[k];
            r_div_q[k]   <= w_div_q_nx[k];
            r_div_cnt[k] <= w_div_cnt_nx[k];
            r_tmr[k]     <= w_tmr_nx[k];
`ifdef CLK_DIV_GEN_PULSE_CNT_EN
            r_pcnt[k]    <= w_pcnt_nx[k];
`endif
         end
         r_en   <= w_en_nx;
         r_tgl  <= w_tgl_nx;
         r_lock <= w_lock_nx;
      end
   end

   // Bypass only forces the visible enable; the divider and lock state keep running underneath.
   assign bus.io_clk_en  = r_en | bus.io_bypass;
   assign bus.io_clk_tgl = r_tgl;
   assign bus.io_lock    = r_lock;
endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen (CH=2, DIV_W=8, SETTLE=10, LOCK=100): startup, ratio change,
// bypass, reset while locked, ratio 0/1; pulse counters are checked when the macro is defined.
module tb_clk_div_gen;
   logic clock;
   logic reset;
   int   cyc;
   int   n_chk;
   int   n_pass;

   clk_div_gen_if #(.CH(2), .DIV_W(8)) bus ();

   clk_div_gen #(
      .CH(2), .DIV_W(8), .SETTLE_CYCLES(10), .LOCK_CYCLES(100)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic logic exp_pulse(input int c, input int start, input int n);
      return (c >= start) && (((c - start) % n) == 0);
   endfunction

   function automatic logic exp_tgl(input int c, input int start, input int n);
      return (c >= start) && ((((c - start) / n) % 2) == 0);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic apply_reset(input int n);
      reset = 1'b1;
      repeat (n) @(posedge clock);
      #1;
      chk("rst_clk_en",  {30'd0, bus.io_clk_en},  32'd0);
      chk("rst_clk_tgl", {30'd0, bus.io_clk_tgl}, 32'd0);
      chk("rst_lock",    {30'd0, bus.io_lock},    32'd0);
      reset = 1'b0;
      cyc   = 0;
   endtask

   // Checks every cycle up to 'last' against closed-form pulse/toggle/lock times.
   task automatic run_window(input int last, input int s0, input int n0, input int s1,
                             input int n1, input int lk0, input int lk1, input logic [1:0] tgl_mask);
      logic [1:0] e_en;
      logic [1:0] e_lk;
      logic [1:0] e_tgl;
      while (cyc < last) begin
         tick();
         e_en  = {exp_pulse(cyc, s1, n1), exp_pulse(cyc, s0, n0)};
         e_lk  = {logic'(cyc >= lk1), logic'(cyc >= lk0)};
         e_tgl = {exp_tgl(cyc, s1, n1), exp_tgl(cyc, s0, n0)};
         chk("clk_en", {30'd0, bus.io_clk_en}, {30'd0, e_en});
         chk("lock",   {30'd0, bus.io_lock},   {30'd0, e_lk});
         if (tgl_mask[0]) chk("tgl0", {31'd0, bus.io_clk_tgl[0]}, {31'd0, e_tgl[0]});
         if (tgl_mask[1]) chk("tgl1", {31'd0, bus.io_clk_tgl[1]}, {31'd0, e_tgl[1]});
      end
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      cyc    = 0;
      reset  = 1'b1;
      bus.io_bypass = 2'b00;
      bus.io_div    = {8'd2, 8'd4};

      // Startup: ch1 N=2 pulses from 12, ch0 N=4 from 14, lock at 110.
      apply_reset(3);
      run_window(112, 14, 4, 12, 2, 110, 110, 2'b11);

      // Ratio change on locked ch0 to 3 at edge 113.
      bus.io_div = {8'd2, 8'd3};
      run_window(215, 116, 3, 12, 2, 213, 110, 2'b10);

      // Bypass ch1 for 20 cycles while locked.
      bus.io_bypass = 2'b10;
      while (cyc < 235) begin
         tick();
         chk("byp_en1",   {31'd0, bus.io_clk_en[1]}, 32'd1);
         chk("byp_lock1", {31'd0, bus.io_lock[1]},   32'd1);
         chk("byp_en0",   {31'd0, bus.io_clk_en[0]}, {31'd0, exp_pulse(cyc, 116, 3)});
      end
      bus.io_bypass = 2'b00;
      run_window(245, 116, 3, 12, 2, 213, 110, 2'b10);

      // One-cycle reset while locked: startup timing repeats.
      bus.io_div = {8'd2, 8'd4};
      apply_reset(1);
      run_window(112, 14, 4, 12, 2, 110, 110, 2'b11);

      // Ratio 0 on ch0 and 1 on ch1: enable every cycle from 11.
      bus.io_div = {8'd1, 8'd0};
      apply_reset(1);
      run_window(30, 11, 1, 11, 1, 110, 110, 2'b11);

`ifdef CLK_DIV_GEN_PULSE_CNT_EN
      chk("pcnt0_20", {16'd0, bus.io_pulse_cnt[15:0]},  32'd20);
      chk("pcnt1_20", {16'd0, bus.io_pulse_cnt[31:16]}, 32'd20);
      bus.io_bypass = 2'b11;
      repeat (10) tick();
      bus.io_bypass = 2'b00;
      while (cyc < 10 + 65537) tick();
      chk("pcnt0_wrap", {16'd0, bus.io_pulse_cnt[15:0]},  32'd1);
      chk("pcnt1_wrap", {16'd0, bus.io_pulse_cnt[31:16]}, 32'd1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
